// File: rtl/emugen_pkg.sv
// Shared definitions for the multi-channel spill/trigger emulator:
// sequencer state encoding, LFSR tap mask and default LFSR seed.
package emugen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
    } state_t;

    // Fibonacci taps 16,14,13,11 expressed as a mask on bits [15:0]
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used as the period jitter source.
// Only built when EMUGEN_JITTER_EN is defined; otherwise the emulator
// has no random source and this file contributes no module.
`ifdef EMUGEN_JITTER_EN
module lfsr16
    import emugen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    // Reseed on reset, then advance one step every clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= seed;
        end else begin
            out <= lfsr_next(out);
        end
    end

endmodule
`endif

// File: rtl/emugen_multi.sv
// Multi-channel spill/trigger emulator: IDLE/ON/OFF spill sequencer with
// NCH phase-staggered periodic trigger pulses during ON, shadowed run-time
// timing config, and spill/trigger counters.
// Optional feature macro: EMUGEN_JITTER_EN (adds LFSR period jitter).
module emugen_multi
    import emugen_pkg::*;
#(
    parameter int unsigned NCH      = 4,
    parameter int unsigned CNTW     = 24,
    parameter int unsigned PERIOD   = 40,
    parameter int unsigned CYCLEON  = 1000,
    parameter int unsigned CYCLEOFF = 500,
    parameter int unsigned PHASE    = 10,
    parameter int unsigned WIDTH    = 1,
    parameter logic [15:0] JMASK    = 16'd15,
    parameter logic [15:0] SEED     = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            cfg_wr,
    input  logic [CNTW-1:0] cfg_period,
    input  logic [CNTW-1:0] cfg_on,
    input  logic [CNTW-1:0] cfg_off,
    input  logic [CNTW-1:0] cfg_phase,
    output logic            cfg_pend,
    output logic            spill,
    output logic [NCH-1:0]  trig,
    output logic [15:0]     spill_cnt,
    output logic [CNTW-1:0] trig_cnt
);

    // Period counter is one bit wider so period + jitter cannot overflow;
    // channel offsets need room for (NCH-1) * phase.
    localparam int unsigned PW = CNTW + 1;
    localparam int unsigned OW = CNTW + 5;

    function automatic logic [CNTW-1:0] clamp1(input logic [CNTW-1:0] v);
        return (v == '0) ? CNTW'(1) : v;
    endfunction

    state_t          state, state_n;
    logic [CNTW-1:0] ocnt, ocnt_n;
    logic [PW-1:0]   pcnt, pcnt_n;
    logic [PW-1:0]   plen, plen_n;
    logic [PW-1:0]   jit;
    logic            enter;

    logic [CNTW-1:0] act_period, act_on, act_off, act_phase;
    logic [CNTW-1:0] sh_period, sh_on, sh_off, sh_phase;
    logic [CNTW-1:0] wr_period, wr_on, wr_off;
    logic [CNTW-1:0] e_period, e_phase, ph_sel;
    logic [NCH-1:0]  trig_n;

`ifdef EMUGEN_JITTER_EN
    logic [15:0] lfsr_q;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (SEED),
        .out  (lfsr_q)
    );

    assign jit = PW'(lfsr_q & JMASK);
`else
    logic unused_jitter;

    assign unused_jitter = ^{JMASK, SEED};
    assign jit           = '0;
`endif

    assign wr_period = clamp1(cfg_period);
    assign wr_on     = clamp1(cfg_on);
    assign wr_off    = clamp1(cfg_off);

    // Config that becomes active on ON entry: a write in IDLE takes effect
    // at once, otherwise a pending shadow is promoted.
    always_comb begin
        e_period = act_period;
        e_phase  = act_phase;
        if (state == IDLE && cfg_wr) begin
            e_period = wr_period;
            e_phase  = cfg_phase;
        end else if (cfg_pend) begin
            e_period = sh_period;
            e_phase  = sh_phase;
        end
    end

    // Next-state, phase-length and period-position logic
    always_comb begin
        state_n = state;
        ocnt_n  = ocnt;
        pcnt_n  = pcnt;
        plen_n  = plen;
        enter   = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: enter = 1'b1;
                ON: begin
                    if (ocnt == act_on - CNTW'(1)) begin
                        state_n = OFF;
                        ocnt_n  = '0;
                    end else begin
                        ocnt_n = ocnt + CNTW'(1);
                    end
                    if (pcnt == plen - PW'(1)) begin
                        pcnt_n = '0;
                        plen_n = {1'b0, act_period} + jit;
                    end else begin
                        pcnt_n = pcnt + PW'(1);
                    end
                end
                OFF: begin
                    if (ocnt == act_off - CNTW'(1)) begin
                        enter = 1'b1;
                    end else begin
                        ocnt_n = ocnt + CNTW'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (enter) begin
            state_n = ON;
            ocnt_n  = '0;
            pcnt_n  = '0;
            plen_n  = {1'b0, e_period} + jit;
        end
    end

    // Per-channel window decode on the next period position
    always_comb begin
        logic [OW-1:0] offk;
        ph_sel = enter ? e_phase : act_phase;
        trig_n = '0;
        offk   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            offk      = OW'(k) * OW'(ph_sel);
            trig_n[k] = (state_n == ON) && (OW'(pcnt_n) >= offk)
                        && (OW'(pcnt_n) < offk + OW'(WIDTH));
        end
    end

    // Sequencer state and timing counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ocnt  <= '0;
            pcnt  <= '0;
            plen  <= PW'(1);
        end else begin
            state <= state_n;
            ocnt  <= ocnt_n;
            pcnt  <= pcnt_n;
            plen  <= plen_n;
        end
    end

    // Active/shadow config registers and the pending flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_period <= CNTW'(PERIOD);
            act_on     <= CNTW'(CYCLEON);
            act_off    <= CNTW'(CYCLEOFF);
            act_phase  <= CNTW'(PHASE);
            sh_period  <= CNTW'(PERIOD);
            sh_on      <= CNTW'(CYCLEON);
            sh_off     <= CNTW'(CYCLEOFF);
            sh_phase   <= CNTW'(PHASE);
            cfg_pend   <= 1'b0;
        end else if (state == IDLE && cfg_wr) begin
            act_period <= wr_period;
            act_on     <= wr_on;
            act_off    <= wr_off;
            act_phase  <= cfg_phase;
            sh_period  <= wr_period;
            sh_on      <= wr_on;
            sh_off     <= wr_off;
            sh_phase   <= cfg_phase;
            cfg_pend   <= 1'b0;
        end else begin
            // promotion uses the old shadow; a same-edge write stays pending
            if (enter && cfg_pend) begin
                act_period <= sh_period;
                act_on     <= sh_on;
                act_off    <= sh_off;
                act_phase  <= sh_phase;
            end
            if (cfg_wr) begin
                sh_period <= wr_period;
                sh_on     <= wr_on;
                sh_off    <= wr_off;
                sh_phase  <= cfg_phase;
                cfg_pend  <= 1'b1;
            end else if (enter) begin
                cfg_pend <= 1'b0;
            end
        end
    end

    // Registered outputs and spill/trigger counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spill     <= 1'b0;
            trig      <= '0;
            spill_cnt <= '0;
            trig_cnt  <= '0;
        end else begin
            spill <= (state_n == ON);
            trig  <= trig_n;
            if (enter) begin
                spill_cnt <= spill_cnt + 16'd1;
                trig_cnt  <= CNTW'(trig_n[0]);
            end else if (trig_n[0] && !trig[0] && trig_cnt != '1) begin
                trig_cnt <= trig_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_emugen_multi.sv
// Self-checking bench for emugen_multi (default build, no jitter).
// Reference model tracks time since ON entry and derives pulses with modulo
// arithmetic; directed phases follow the bring-up scenarios, then random
// config writes, enable toggles and resets.
module tb_emugen_multi;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CNTW  = 24;
    localparam int unsigned WIDTH = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic            cfg_wr;
    logic [CNTW-1:0] cfg_period, cfg_on, cfg_off, cfg_phase;
    logic            cfg_pend;
    logic            spill;
    logic [NCH-1:0]  trig;
    logic [15:0]     spill_cnt;
    logic [CNTW-1:0] trig_cnt;

    int unsigned n_checks = 0;
    int unsigned n_errs   = 0;
    int unsigned cycle    = 0;

    emugen_multi #(
        .NCH   (NCH),
        .CNTW  (CNTW),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cfg_wr     (cfg_wr),
        .cfg_period (cfg_period),
        .cfg_on     (cfg_on),
        .cfg_off    (cfg_off),
        .cfg_phase  (cfg_phase),
        .cfg_pend   (cfg_pend),
        .spill      (spill),
        .trig       (trig),
        .spill_cnt  (spill_cnt),
        .trig_cnt   (trig_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit          m_act, m_on, m_pend;
    int unsigned t;
    int unsigned a_per, a_on, a_off, a_ph;
    int unsigned s_per, s_on, s_off, s_ph;
    int unsigned m_scnt, m_tcnt;

    function automatic int unsigned clamp(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic model_reset();
        m_act = 0; m_on = 0; m_pend = 0; t = 0;
        a_per = 40; a_on = 1000; a_off = 500; a_ph = 10;
        s_per = 40; s_on = 1000; s_off = 500; s_ph = 10;
        m_scnt = 0; m_tcnt = 0;
    endtask

    task automatic model_step();
        bit was_idle;
        bit entering;
        was_idle = !m_act;
        entering = 0;
        if (was_idle && cfg_wr) begin
            a_per = clamp(cfg_period); a_on = clamp(cfg_on);
            a_off = clamp(cfg_off);    a_ph = cfg_phase;
            s_per = a_per; s_on = a_on; s_off = a_off; s_ph = a_ph;
            m_pend = 0;
        end
        if (!enable) begin
            m_act = 0; m_on = 0;
        end else if (was_idle) begin
            entering = 1;
        end else if (m_on) begin
            if (t + 1 == a_on) begin m_on = 0; t = 0; end
            else t++;
        end else begin
            if (t + 1 == a_off) entering = 1;
            else t++;
        end
        if (entering) begin
            if (m_pend) begin
                a_per = s_per; a_on = s_on; a_off = s_off; a_ph = s_ph;
            end
            m_pend = 0; m_act = 1; m_on = 1; t = 0;
            m_scnt = (m_scnt + 1) % 65536;
        end
        if (!was_idle && cfg_wr) begin
            s_per = clamp(cfg_period); s_on = clamp(cfg_on);
            s_off = clamp(cfg_off);    s_ph = cfg_phase;
            m_pend = 1;
        end
        if (m_on) m_tcnt = (a_per > WIDTH) ? t / a_per + 1 : 1;
    endtask

    function automatic logic [NCH-1:0] exp_trig();
        logic [NCH-1:0] v;
        int unsigned r;
        v = '0;
        r = t % a_per;
        for (int unsigned k = 0; k < NCH; k++)
            v[k] = m_on && (r >= k * a_ph) && (r < k * a_ph + WIDTH);
        return v;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cycle++;
        if (rst) model_reset();
        else model_step();
        #1;
        check("spill", 64'(spill), 64'(m_on));
        check("trig", 64'(trig), 64'(exp_trig()));
        check("cfg_pend", 64'(cfg_pend), 64'(m_pend));
        check("spill_cnt", 64'(spill_cnt), 64'(m_scnt));
        check("trig_cnt", 64'(trig_cnt), 64'(m_tcnt));
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic write_cfg(input int unsigned p, input int unsigned on,
                             input int unsigned off, input int unsigned ph);
        cfg_period = CNTW'(p); cfg_on = CNTW'(on);
        cfg_off = CNTW'(off);  cfg_phase = CNTW'(ph);
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_spill", 64'(spill), 64'd0);
        check("rst_trig", 64'(trig), 64'd0);
        check("rst_spill_cnt", 64'(spill_cnt), 64'd0);
        check("rst_trig_cnt", 64'(trig_cnt), 64'd0);
        check("rst_cfg_pend", 64'(cfg_pend), 64'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int unsigned n;
        rst = 1'b1; enable = 1'b0; cfg_wr = 1'b0;
        cfg_period = '0; cfg_on = '0; cfg_off = '0; cfg_phase = '0;
        model_reset();
        run(2);
        rst = 1'b0;
        run(38);

        // Defaults: 1000 ON / 500 OFF, 25 pulses per spill
        enable = 1'b1;
        run(1000);
        check("on_last_cycle", 64'(spill), 64'd1);
        check("pulses_per_spill", 64'(trig_cnt), 64'd25);
        tick();
        check("off_first_cycle", 64'(spill), 64'd0);
        run(700);

        // Phase 15 written mid-ON: channel 3 offset 45 >= 40 next spill
        write_cfg(40, 1000, 500, 15);
        run(2600);

        // Period 100 written mid-ON: pending until next ON entry
        run(200);
        write_cfg(100, 1000, 500, 10);
        check("pend_after_wr", 64'(cfg_pend), 64'd1);
        run(2000);

        // Enable dropped mid-ON, then restored
        run(300);
        enable = 1'b0;
        tick();
        check("spill_after_disable", 64'(spill), 64'd0);
        run(20);
        enable = 1'b1;
        run(600);

        // Reset during a trig[0] pulse
        n = 0;
        while (!trig[0] && n < 200) begin tick(); n++; end
        check("wait_trig0", 64'(trig[0]), 64'd1);
        enable = 1'b0;
        pulse_reset();

        // Period 0 clamps to 1: trig[0] high every ON cycle
        write_cfg(0, 50, 20, 3);
        enable = 1'b1;
        run(200);

        // Random config writes, enable toggles and resets
        for (int i = 0; i < 6000; i++) begin
            cfg_wr = ($urandom_range(0, 149) == 0);
            if (cfg_wr) begin
                cfg_period = CNTW'($urandom_range(0, 30));
                cfg_on     = CNTW'($urandom_range(0, 80));
                cfg_off    = CNTW'($urandom_range(0, 30));
                cfg_phase  = CNTW'($urandom_range(0, 12));
            end
            if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            if ($urandom_range(0, 2499) == 0) pulse_reset();
            else tick();
        end
        cfg_wr = 1'b0;
        run(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errs);
        $finish;
    end

endmodule
